watchdog_mc: RTL

Multi-channel, parametrised timeout watchdog for the SPI execution unit. Each of CH independent channels counts down from a programmed value and raises a sticky, acknowledgeable interrupt on reaching zero. Channels run in auto-reload or one-shot mode, can be refreshed (kicked) by the controller, and record overruns when an expiry occurs while the previous one is still unacknowledged. The block replaces the single-channel, pulse-output watchdog in the exe unit's interrupt path.

---
 rtl/watchdog_pkg.sv | 11 +
 rtl/watchdog_mc_if.sv | 31 +++
 rtl/watchdog_ch.sv | 81 ++++++++
 rtl/watchdog_mc.sv | 43 ++++
 4 files changed

// File: rtl/watchdog_pkg.sv
// Shared types for the multi-channel watchdog: channel mode encoding and
// the channel-select width helper.
package watchdog_pkg;

  typedef enum logic {WDG_RELOAD = 1'b0, WDG_ONESHOT = 1'b1} wdg_mode_t;

  function automatic int sel_width(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/watchdog_mc_if.sv
// Configuration / kick / ack bus and per-channel status outputs of watchdog_mc.
interface watchdog_mc_if
  import watchdog_pkg::*;
#(
  parameter int N  = 8,
  parameter int CH = 4,
  parameter int SW = sel_width(CH)
);

  logic          i_we;
  logic [SW-1:0] i_sel;
  logic [N-1:0]  i_cycles;
  logic          i_mode;
  logic [CH-1:0] i_kick;
  logic [CH-1:0] i_ack;
  logic [CH-1:0] o_pend;
  logic [CH-1:0] o_ovf;
  logic          o_irq;
  logic [CH-1:0] o_active;

  modport master (
    output i_we, i_sel, i_cycles, i_mode, i_kick, i_ack,
    input  o_pend, o_ovf, o_irq, o_active
  );

  modport slave (
    input  i_we, i_sel, i_cycles, i_mode, i_kick, i_ack,
    output o_pend, o_ovf, o_irq, o_active
  );

endinterface

// File: rtl/watchdog_ch.sv
// One watchdog channel: period/count registers, expiry, sticky pend/overrun.
// Flags are registered; o_active is decoded from registered state only.
module watchdog_ch
  import watchdog_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         i_clk_p,
  input  logic         i_rst_n,
  input  logic         i_we,
  input  logic [N-1:0] i_cycles,
  input  logic         i_mode,
  input  logic         i_kick,
  input  logic         i_ack,
  output logic         o_pend,
  output logic         o_ovf,
  output logic         o_active
);

  typedef struct packed {
    logic [N-1:0] cycles;
    logic [N-1:0] count;
    wdg_mode_t    mode;
    logic         halt;
    logic         pend;
    logic         ovf;
  } wdg_ch_state_t;

  wdg_ch_state_t st_q, st_d;
  logic          enabled;
  logic          run;
  logic          expire;

  always_comb begin
    enabled = (st_q.cycles != '0);
    run     = enabled && !st_q.halt;
    expire  = run && (st_q.count == '0) && !i_we && !i_kick;
    st_d    = st_q;

    if (i_we) begin
      st_d.cycles = i_cycles;
      st_d.count  = i_cycles;
      st_d.mode   = wdg_mode_t'(i_mode);
      st_d.halt   = 1'b0;
    end else if (i_kick && enabled) begin
      st_d.count = st_q.cycles;
      st_d.halt  = 1'b0;
    end else if (expire) begin
      // One-shot parks at zero; only a write or kick restarts it.
      if (st_q.mode == WDG_ONESHOT) begin
        st_d.halt = 1'b1;
      end else begin
        st_d.count = st_q.cycles;
      end
    end else if (run) begin
      st_d.count = st_q.count - N'(1);
    end

    // A coincident ack consumes the old expiry, so no overrun is recorded.
    if (expire) begin
      st_d.pend = 1'b1;
      st_d.ovf  = !i_ack && (st_q.pend || st_q.ovf);
    end else if (i_ack) begin
      st_d.pend = 1'b0;
      st_d.ovf  = 1'b0;
    end
  end

  always_ff @(posedge i_clk_p) begin
    if (!i_rst_n) begin
      st_q <= '0;
    end else begin
      st_q <= st_d;
    end
  end

  assign o_pend   = st_q.pend;
  assign o_ovf    = st_q.ovf;
  assign o_active = run;

endmodule

// File: rtl/watchdog_mc.sv
// Multi-channel timeout watchdog: decodes writes to CH channel instances and
// merges their sticky expiry flags into a single interrupt.
module watchdog_mc
  import watchdog_pkg::*;
#(
  parameter int N  = 8,
  parameter int CH = 4,
  parameter int SW = sel_width(CH)
) (
  input  logic          i_clk_p,
  input  logic          i_rst_n,
  watchdog_mc_if.slave  bus
);

  logic [CH-1:0] we_ch;
  logic [CH-1:0] pend_w;
  logic [CH-1:0] ovf_w;
  logic [CH-1:0] act_w;

  for (genvar k = 0; k < CH; k++) begin : g_ch
    // Select values with no matching channel simply produce no write enable.
    assign we_ch[k] = bus.i_we && (bus.i_sel == SW'(k));

    watchdog_ch #(.N(N)) u_ch (
      .i_clk_p  (i_clk_p),
      .i_rst_n  (i_rst_n),
      .i_we     (we_ch[k]),
      .i_cycles (bus.i_cycles),
      .i_mode   (bus.i_mode),
      .i_kick   (bus.i_kick[k]),
      .i_ack    (bus.i_ack[k]),
      .o_pend   (pend_w[k]),
      .o_ovf    (ovf_w[k]),
      .o_active (act_w[k])
    );
  end

  assign bus.o_pend   = pend_w;
  assign bus.o_ovf    = ovf_w;
  assign bus.o_active = act_w;
  assign bus.o_irq    = |pend_w;

endmodule
